microcode_sequencer: RTL and testbench

- Owns the fetch/decode/execute control loop of the CPU.
- Fetches each 16-bit instruction over a req/ack memory handshake and latches it in the instruction register. Forms the 11-bit microcode ROM address and steps the 4-bit micro-step index.
- Handles end-of-instruction, memory wait steps, halt requests and runaway microcode.
- Sits between the memory controller, the microcode ROM and the execution/control-bundle decoder. Decoder control bundles are qualified by ctrl_valid.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/mc_step_counter.sv | 24 ++
 rtl/microcode_sequencer.sv | 106 ++++++++++
 tb/tb_microcode_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the microcode sequencer
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int INSTR_W = 16;
    localparam int MC_W    = 26;

    // Microcode word control bits
    localparam int MC_END_BIT  = 22;
    localparam int MC_WAIT_BIT = 23;

    localparam logic [INSTR_W-1:0] MC_RESET_INSTR = 16'h0000;

    // mc_addr = {opcode, |instr[11:10], |instr[9:8], instr[1], step}
    localparam int MC_OP_W   = 4;
    localparam int MC_MOD_W  = 3;
    localparam int STEP_W    = 4;
    localparam int MC_ADDR_W = MC_OP_W + MC_MOD_W + STEP_W;

    function automatic logic [MC_ADDR_W-1:0] form_mc_addr(
        input logic [INSTR_W-1:0] instr,
        input logic [STEP_W-1:0]  step
    );
        return {instr[15:12], |instr[11:10], |instr[9:8], instr[1], step};
    endfunction

endpackage

// File: rtl/mc_step_counter.sv
// rtl/mc_step_counter.sv - 4-bit micro-step counter with hold/clear/increment
// Ports: clock, reset (sync, active-high), clear, incr -> count, terminal (count==15).
module mc_step_counter
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              incr,
    output logic [STEP_W-1:0] count,
    output logic              terminal
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == '1);

endmodule

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - fetch/decode/execute control loop
// Ports: clock, reset, run, halt_req, mem_ack, mem_rdata, microcode in;
//        mem_req, mem_fetch, instruction, mc_addr, step, ctrl_valid, halted, fault out.
module microcode_sequencer
    import cpu_pkg::*;
#(
    parameter int                 END_BIT     = MC_END_BIT,
    parameter int                 WAIT_BIT    = MC_WAIT_BIT,
    parameter logic [INSTR_W-1:0] RESET_INSTR = MC_RESET_INSTR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 halt_req,
    input  logic                 mem_ack,
    input  logic [INSTR_W-1:0]   mem_rdata,
    input  logic [MC_W-1:0]      microcode,
    output logic                 mem_req,
    output logic                 mem_fetch,
    output logic [INSTR_W-1:0]   instruction,
    output logic [MC_ADDR_W-1:0] mc_addr,
    output logic [STEP_W-1:0]    step,
    output logic                 ctrl_valid,
    output logic                 halted,
    output logic                 fault
);

    state_t state;

    logic in_exec;
    logic is_wait;
    logic is_end;
    logic step_done;
    logic step_clear;
    logic step_incr;
    logic step_terminal;
    logic unused_mc;

    assign in_exec = (state == ST_EXEC);
    assign is_wait = microcode[WAIT_BIT];
    assign is_end  = microcode[END_BIT];

    // A WAIT step completes in the cycle its mem_ack arrives.
    assign step_done = !is_wait || mem_ack;

    assign step_clear = ((state == ST_FETCH) && mem_ack) ||
                        (in_exec && step_done && is_end);
    // At step 15 without END the counter holds; the FSM flags the fault.
    assign step_incr  = in_exec && step_done && !is_end && !step_terminal;

    mc_step_counter u_step (
        .clock    (clock),
        .reset    (reset),
        .clear    (step_clear),
        .incr     (step_incr),
        .count    (step),
        .terminal (step_terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            instruction <= RESET_INSTR;
            fault       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (step_done) begin
                        if (is_end) begin
                            if (halt_req)  state <= ST_HALT;
                            else if (run)  state <= ST_FETCH;
                            else           state <= ST_IDLE;
                        end else if (step_terminal) begin
                            fault <= 1'b1;
                            state <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (!halt_req && run && !fault) state <= ST_FETCH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are pure decodes of the state register, except the WAIT
    // request which must follow the combinational ROM word of this step.
    assign mem_fetch  = (state == ST_FETCH);
    assign mem_req    = mem_fetch || (in_exec && is_wait);
    assign ctrl_valid = in_exec;
    assign halted     = (state == ST_HALT);
    assign mc_addr    = form_mc_addr(instruction, step);

    assign unused_mc  = ^microcode;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - self-checking bench for microcode_sequencer
module tb_microcode_sequencer;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        halt_req;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [25:0] microcode;
    logic        mem_req;
    logic        mem_fetch;
    logic [15:0] instruction;
    logic [10:0] mc_addr;
    logic [3:0]  step;
    logic        ctrl_valid;
    logic        halted;
    logic        fault;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural ROM: one active program, END step index (16 = none) and WAIT mask.
    logic [15:0] rom_wait;
    int          rom_end;

    typedef struct {
        int s;
        bit w;
        bit ack;
    } cyc_t;

    localparam int OUT_IDLE  = 0;
    localparam int OUT_FETCH = 1;
    localparam int OUT_HALT  = 2;
    localparam int OUT_FAULT = 3;

    microcode_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .halt_req    (halt_req),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .microcode   (microcode),
        .mem_req     (mem_req),
        .mem_fetch   (mem_fetch),
        .instruction (instruction),
        .mc_addr     (mc_addr),
        .step        (step),
        .ctrl_valid  (ctrl_valid),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clock = ~clock;

    always_comb begin
        microcode           = '0;
        microcode[10:0]     = mc_addr;
        microcode[23]       = rom_wait[mc_addr[3:0]];
        microcode[22]       = (rom_end == int'(mc_addr[3:0]));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [10:0] exp_addr(input logic [15:0] i, input int s);
        logic [3:0] s4;
        s4 = s[3:0];
        return {i[15:12], (i[11:10] != 2'b00), (i[9:8] != 2'b00), i[1], s4};
    endfunction

    // Precondition: DUT observed in FETCH. Acks after lat idle request cycles.
    task automatic do_fetch(input logic [15:0] instr, input int lat);
        for (int c = 0; c <= lat; c++) begin
            check("fetch_req", 32'(mem_req), 1);
            check("fetch_flag", 32'(mem_fetch), 1);
            check("fetch_cv", 32'(ctrl_valid), 0);
            if (c == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = instr;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
        end
        check("instr_latch", 32'(instruction), 32'(instr));
        check("exec_step0", 32'(step), 0);
    endtask

    // Expands the program into an expected per-cycle trace, then walks it.
    task automatic exec_instr(input logic [15:0] instr, input int end_s, input logic [15:0] wmask,
                              input int halt_s, input bit run_after, input int wdelay,
                              output int outcome);
        cyc_t q[$];
        int   last;
        int   d;
        bit   halt_seen;
        last      = (end_s < 16) ? end_s : 15;
        halt_seen = 0;
        for (int s = 0; s <= last; s++) begin
            if (wmask[s]) begin
                d = (wdelay >= 0) ? wdelay : int'($urandom_range(0, 3));
                for (int k = 0; k <= d; k++) q.push_back('{s: s, w: 1'b1, ack: (k == d)});
            end else begin
                q.push_back('{s: s, w: 1'b0, ack: 1'b1});
            end
        end
        run = run_after;
        foreach (q[i]) begin
            if (q[i].s == halt_s) begin
                halt_req  = 1'b1;
                halt_seen = 1;
            end
            check("exec_cv", 32'(ctrl_valid), 1);
            check("exec_step", 32'(step), q[i].s);
            check("exec_req", 32'(mem_req), 32'(q[i].w));
            check("exec_fetch", 32'(mem_fetch), 0);
            check("exec_addr", 32'(mc_addr), 32'(exp_addr(instr, q[i].s)));
            mem_ack = q[i].w && q[i].ack;
            tick();
            mem_ack = 1'b0;
        end
        check("post_cv", 32'(ctrl_valid), 0);
        if (end_s >= 16) begin
            outcome = OUT_FAULT;
            check("runaway_fault", 32'(fault), 1);
            check("runaway_halted", 32'(halted), 1);
            check("runaway_step", 32'(step), 15);
            check("runaway_req", 32'(mem_req), 0);
        end else begin
            check("end_step0", 32'(step), 0);
            check("end_fault", 32'(fault), 0);
            if (halt_seen) begin
                outcome = OUT_HALT;
                check("end_halted", 32'(halted), 1);
                check("end_halt_req", 32'(mem_req), 0);
            end else if (run_after) begin
                outcome = OUT_FETCH;
                check("end_fetch", 32'(mem_fetch), 1);
                check("end_fetch_req", 32'(mem_req), 1);
            end else begin
                outcome = OUT_IDLE;
                check("end_idle_req", 32'(mem_req), 0);
                check("end_idle_halted", 32'(halted), 0);
            end
        end
    endtask

    // Brings the DUT back to an observed FETCH state.
    task automatic recover(input int outcome);
        case (outcome)
            OUT_IDLE: begin
                run = 1'b1;
                tick();
            end
            OUT_HALT: begin
                run = 1'b1;
                tick();
                check("halt_hold", 32'(halted), 1);
                halt_req = 1'b0;
                tick();
                check("halt_exit", 32'(mem_fetch), 1);
            end
            OUT_FAULT: begin
                run      = 1'b1;
                halt_req = 1'b0;
                tick();
                tick();
                check("fault_no_restart", 32'(halted), 1);
                check("fault_sticky", 32'(fault), 1);
                check("fault_no_req", 32'(mem_req), 0);
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("fault_cleared", 32'(fault), 0);
                check("fault_rst_halted", 32'(halted), 0);
                tick();
            end
            default: ;
        endcase
    endtask

    initial begin
        int          outcome;
        logic [15:0] instr;
        int          end_s;
        int          halt_s;
        int          lat;
        bit          run_after;

        reset     = 1'b1;
        run       = 1'b0;
        halt_req  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        rom_wait  = 16'h0000;
        rom_end   = 16;
        tick();
        tick();
        reset = 1'b0;

        check("rst_req", 32'(mem_req), 0);
        check("rst_fetch", 32'(mem_fetch), 0);
        check("rst_cv", 32'(ctrl_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_step", 32'(step), 0);
        check("rst_instr", 32'(instruction), 0);
        tick();
        check("idle_stays", 32'(mem_req), 0);

        // Basic fetch, then 3-step instruction followed by fetch.
        run = 1'b1;
        tick();
        rom_end  = 2;
        rom_wait = 16'h0000;
        do_fetch(16'h3A05, 1);
        check("addr_3A05", 32'(mc_addr), 32'h1E0);
        exec_instr(16'h3A05, 2, 16'h0000, -1, 1'b1, -1, outcome);

        // WAIT at step 1 held for 5 cycles.
        rom_end  = 3;
        rom_wait = 16'h0002;
        do_fetch(16'h1234, 0);
        exec_instr(16'h1234, 3, 16'h0002, -1, 1'b1, 4, outcome);

        // Runaway microcode.
        rom_end  = 16;
        rom_wait = 16'h0000;
        do_fetch(16'hC3F2, 2);
        exec_instr(16'hC3F2, 16, 16'h0000, -1, 1'b1, -1, outcome);
        recover(outcome);

        // halt_req mid-instruction.
        rom_end  = 3;
        rom_wait = 16'h0000;
        do_fetch(16'h5501, 0);
        exec_instr(16'h5501, 3, 16'h0000, 1, 1'b1, -1, outcome);
        recover(outcome);

        // Reset in the middle of a fetch with a coincident ack.
        check("pre_rst_fetch", 32'(mem_fetch), 1);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
        check("rst_fetch_instr", 32'(instruction), 0);
        check("rst_fetch_req", 32'(mem_req), 0);
        check("rst_fetch_cv", 32'(ctrl_valid), 0);
        tick();

        // Randomized instructions against the trace model.
        for (int n = 0; n < 40; n++) begin
            instr     = 16'($urandom);
            lat       = int'($urandom_range(0, 3));
            end_s     = ($urandom_range(0, 7) == 0) ? 16 : int'($urandom_range(0, 6));
            halt_s    = ($urandom_range(0, 3) == 0) ?
                        int'($urandom_range(0, (end_s < 16) ? end_s : 15)) : -1;
            run_after = 1'($urandom_range(0, 1));
            rom_end   = end_s;
            rom_wait  = 16'($urandom) & 16'($urandom);
            do_fetch(instr, lat);
            exec_instr(instr, end_s, rom_wait, halt_s, run_after, -1, outcome);
            recover(outcome);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
